wb_master_arbiter: RTL and testbench

Two-master Wishbone arbiter placed between the bus masters (the host-side `wishbone_master` and a second master such as a DMA engine) and the single master port of `wishbone_interconnect`. It grants the shared bus to one master per bus cycle using round-robin priority and holds the grant until that master drops `cyc`. It also runs a per-transfer watchdog that terminates a stalled strobe so a missing slave cannot hang the bus.

---
 rtl/wb_master_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter
// Brief    : Two-master Wishbone arbiter with round-robin priority, grant held
//            for the whole bus cycle, and a per-transfer stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_int,

    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_int,

    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    input  logic        i_s_int,

    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int                CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam bit                C_WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last;     // most recently granted master
    logic [CNT_W-1:0]   r_cnt;      // consecutive un-acked strobe cycles
    logic               w_gnt_stb;  // strobe of the current owner
    logic               w_fire;     // watchdog terminates this beat

    // Owner's strobe, zero when idle.
    always_comb begin
        w_gnt_stb = 1'b0;
        case (r_state)
            S_GRANT0: w_gnt_stb = i_m0_stb;
            S_GRANT1: w_gnt_stb = i_m1_stb;
            default:  w_gnt_stb = 1'b0;
        endcase
    end

    // A real ack in the same cycle always wins over the watchdog.
    assign w_fire = C_WDOG_EN && w_gnt_stb && !i_s_ack && (r_cnt == C_TIMEOUT);

    // Next-state: round-robin on ties, grant held until owner drops cyc.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_next = r_last ? S_GRANT0 : S_GRANT1;
                end else if (i_m0_cyc) begin
                    w_next = S_GRANT0;
                end else if (i_m1_cyc) begin
                    w_next = S_GRANT1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_GRANT0: if (!i_m0_cyc) w_next = S_IDLE;
            S_GRANT1: if (!i_m1_cyc) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Round-robin pointer: updated on entry to a grant state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_next == S_GRANT0) begin
            r_last <= 1'b0;
        end else if (r_state == S_IDLE && w_next == S_GRANT1) begin
            r_last <= 1'b1;
        end
    end

    // Watchdog counter: counts stalled strobe cycles, clears on any progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!C_WDOG_EN || !w_gnt_stb || i_s_ack || w_fire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bus steering: mirror the owner onto the slave port and route ack/data back.
    always_comb begin
        o_s_we   = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_sel  = 4'h0;
        o_s_adr  = 32'h0;
        o_s_dat  = 32'h0;
        o_m0_ack = 1'b0;
        o_m0_dat = 32'h0;
        o_m1_ack = 1'b0;
        o_m1_dat = 32'h0;
        case (r_state)
            S_GRANT0: begin
                o_s_we   = i_m0_we;
                o_s_cyc  = i_m0_cyc;
                o_s_stb  = i_m0_stb;
                o_s_sel  = i_m0_sel;
                o_s_adr  = i_m0_adr;
                o_s_dat  = i_m0_dat;
                o_m0_ack = i_s_ack;
                o_m0_dat = i_s_dat;
                if (w_fire) begin
                    o_s_stb  = 1'b0;
                    o_m0_ack = 1'b1;
                    o_m0_dat = 32'h0;
                end
            end
            S_GRANT1: begin
                o_s_we   = i_m1_we;
                o_s_cyc  = i_m1_cyc;
                o_s_stb  = i_m1_stb;
                o_s_sel  = i_m1_sel;
                o_s_adr  = i_m1_adr;
                o_s_dat  = i_m1_dat;
                o_m1_ack = i_s_ack;
                o_m1_dat = i_s_dat;
                if (w_fire) begin
                    o_s_stb  = 1'b0;
                    o_m1_ack = 1'b1;
                    o_m1_dat = 32'h0;
                end
            end
            default: begin
                o_s_cyc = 1'b0;
            end
        endcase
    end

    assign o_grant   = {r_state == S_GRANT1, r_state == S_GRANT0};
    assign o_timeout = w_fire;
    assign o_m0_int  = i_s_int;
    assign o_m1_int  = i_s_int;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arbiter
// Brief    : Directed self-checking bench for wb_master_arbiter (TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arbiter;

    localparam int C_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_we, m0_cyc, m0_stb;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic        m0_ack, m0_int;
    logic        m1_we, m1_cyc, m1_stb;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic        m1_ack, m1_int;
    logic        s_we, s_cyc, s_stb;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_ack, s_int;
    logic [1:0]  grant;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_arbiter #(.TIMEOUT(C_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_m0_we   (m0_we),
        .i_m0_cyc  (m0_cyc),
        .i_m0_stb  (m0_stb),
        .i_m0_sel  (m0_sel),
        .i_m0_adr  (m0_adr),
        .i_m0_dat  (m0_dat_w),
        .o_m0_dat  (m0_dat_r),
        .o_m0_ack  (m0_ack),
        .o_m0_int  (m0_int),
        .i_m1_we   (m1_we),
        .i_m1_cyc  (m1_cyc),
        .i_m1_stb  (m1_stb),
        .i_m1_sel  (m1_sel),
        .i_m1_adr  (m1_adr),
        .i_m1_dat  (m1_dat_w),
        .o_m1_dat  (m1_dat_r),
        .o_m1_ack  (m1_ack),
        .o_m1_int  (m1_int),
        .o_s_we    (s_we),
        .o_s_cyc   (s_cyc),
        .o_s_stb   (s_stb),
        .o_s_sel   (s_sel),
        .o_s_adr   (s_adr),
        .o_s_dat   (s_dat_w),
        .i_s_dat   (s_dat_r),
        .i_s_ack   (s_ack),
        .i_s_int   (s_int),
        .o_grant   (grant),
        .o_timeout (timeout)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven 2 ns after the edge, checks 1 ns later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_masters();
        m0_we = 0; m0_cyc = 0; m0_stb = 0; m0_sel = 4'h0; m0_adr = 0; m0_dat_w = 0;
        m1_we = 0; m1_cyc = 0; m1_stb = 0; m1_sel = 4'h0; m1_adr = 0; m1_dat_w = 0;
        s_ack = 0; s_dat_r = 0;
    endtask

    initial begin
        logic [1:0] exp_order [4];
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        idle_masters();
        s_int = 0;
        rst   = 1;
        step(); step();
        rst = 0;
        settle();
        check_eq("reset_grant", 32'(grant), 0);
        check_eq("reset_s_cyc", 32'(s_cyc), 0);
        check_eq("reset_timeout", 32'(timeout), 0);

        // Tie round-robin from reset: m0, m1, m0, m1.
        for (int r = 0; r < 4; r++) begin
            step();
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            settle();
            check_eq($sformatf("tie_idle_%0d", r), 32'(grant), 0);
            step();
            settle();
            check_eq($sformatf("tie_grant_%0d", r), 32'(grant), 32'(exp_order[r]));
            m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        end
        step();
        settle();
        check_eq("tie_end_idle", 32'(grant), 0);

        // Reset during a granted m1 write with an ack in flight.
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
        m1_adr = 32'h0000_0040; m1_dat_w = 32'h1234_5678;
        step();
        settle();
        check_eq("m1w_grant", 32'(grant), 2'b10);
        check_eq("m1w_s_adr", s_adr, 32'h0000_0040);
        check_eq("m1w_s_dat", s_dat_w, 32'h1234_5678);
        check_eq("m1w_s_we", 32'(s_we), 1);
        s_ack = 1; s_dat_r = 32'hAAAA_5555;
        rst = 1;
        step();
        settle();
        check_eq("rst1_grant", 32'(grant), 0);
        check_eq("rst1_s_cyc", 32'(s_cyc), 0);
        check_eq("rst1_m1_ack", 32'(m1_ack), 0);
        check_eq("rst1_s_adr", s_adr, 0);
        step();
        rst = 0;
        settle();
        check_eq("rst2_s_cyc", 32'(s_cyc), 0);
        idle_masters();
        step();

        // Single-master read: ack on the third granted cycle.
        m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_adr = 32'h0100_0004;
        step();
        settle();
        check_eq("rd_grant", 32'(grant), 2'b01);
        check_eq("rd_s_adr", s_adr, 32'h0100_0004);
        check_eq("rd_wait_ack", 32'(m0_ack), 0);
        step();
        step();
        s_ack = 1; s_dat_r = 32'hCAFE_F00D;
        settle();
        check_eq("rd_ack", 32'(m0_ack), 1);
        check_eq("rd_dat", m0_dat_r, 32'hCAFE_F00D);
        check_eq("rd_m1_ack", 32'(m1_ack), 0);
        check_eq("rd_m1_dat", m1_dat_r, 0);
        step();
        idle_masters();
        step();

        // Hold: m1 bursts 4 beats while m0 waits (last = m0, so m1 wins the tie).
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
        step();
        for (int b = 0; b < 4; b++) begin
            s_ack = 1; s_dat_r = 32'h1000_0000 + 32'(b);
            settle();
            check_eq($sformatf("hold_grant_%0d", b), 32'(grant), 2'b10);
            check_eq($sformatf("hold_m1_dat_%0d", b), m1_dat_r, 32'h1000_0000 + 32'(b));
            check_eq($sformatf("hold_m0_ack_%0d", b), 32'(m0_ack), 0);
            step();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        settle();
        check_eq("hold_drop_grant", 32'(grant), 2'b10);
        step();
        settle();
        check_eq("hold_dead_cycle", 32'(grant), 0);
        step();
        settle();
        check_eq("hold_m0_granted", 32'(grant), 2'b01);
        check_eq("hold_m0_adr", s_adr, 32'h0000_0100);
        idle_masters();
        step();

        // Watchdog: slave never acks, forced ack at S+16.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0F00_0000;
        s_dat_r = 32'hDEAD_BEEF;
        step();
        for (int k = 0; k < C_TIMEOUT; k++) begin
            settle();
            if (timeout !== 1'b0 || s_stb !== 1'b1) begin
                check_eq($sformatf("wd_early_%0d", k), {30'd0, timeout, s_stb}, 32'b01);
            end
            step();
        end
        settle();
        check_eq("wd_timeout", 32'(timeout), 1);
        check_eq("wd_ack", 32'(m0_ack), 1);
        check_eq("wd_dat", m0_dat_r, 0);
        check_eq("wd_s_stb", 32'(s_stb), 0);
        step();
        settle();
        check_eq("wd_pulse_once", 32'(timeout), 0);
        check_eq("wd_grant_kept", 32'(grant), 2'b01);
        check_eq("wd_stb_again", 32'(s_stb), 1);
        idle_masters();
        step();
        step();

        // Interrupt passes through while idle.
        s_int = 1;
        settle();
        check_eq("int_m0", 32'(m0_int), 1);
        check_eq("int_m1", 32'(m1_int), 1);
        s_int = 0;
        settle();
        check_eq("int_m0_low", 32'(m0_int), 0);
        step();

        // Ack coincides with the watchdog cycle: real ack wins.
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 0; k < C_TIMEOUT; k++) step();
        s_ack = 1; s_dat_r = 32'h8765_4321;
        settle();
        check_eq("race_timeout", 32'(timeout), 0);
        check_eq("race_ack", 32'(m0_ack), 1);
        check_eq("race_dat", m0_dat_r, 32'h8765_4321);
        check_eq("race_s_stb", 32'(s_stb), 1);
        idle_masters();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
